// File: rtl/regfile_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_ctrl_pkg
// Purpose : Shared widths and the write-back record used by the register-file
//           write-back controller and its load FIFO.
// Contents: REG_ADDR_W - register address width
//           XLEN       - register data width
//           wb_rec_t   - one pending register write {rd, data}
// Revision: 1.0 - initial release
// ============================================================================
package regfile_wb_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_rec_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Purpose : Small synchronous FIFO holding pending write-back records.
//           DEPTH must be a power of two (2 or 4) so the pointers wrap
//           naturally modulo DEPTH.
// Ports   : clk, rst              - clock, asynchronous active-high reset
//           push, push_data       - write an entry (ignored when full)
//           pop, pop_data         - remove the head entry (ignored when empty);
//                                   pop_data always shows the current head
//           full, empty, count    - occupancy status
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic [31:0]
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  T                        push_data,
   input  logic                    pop,
   output T                        pop_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

   T                    r_mem [DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_PTR_W:0]    r_count;

   logic                w_do_push;
   logic                w_do_pop;

   assign full      = (r_count == c_FULL);
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign pop_data  = r_mem[r_rd_ptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: clearing the pointers discards every entry.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_ctrl
// Purpose : Register-file write-back controller. Arbitrates the ALU and the
//           load unit onto a single registered write port and keeps a
//           per-register pending-write scoreboard.
// Ports   : clk, rst                     - clock, async active-high reset
//           alu_valid/ready, alu_rd/data - ALU write-back handshake
//           ld_valid/ready, ld_rd/data   - load write-back handshake
//           iss_valid, iss_rd            - issued instruction destination
//           we, waddr, wdata             - registered register-file write port
//           busy                         - pending-write bit per register
//           ld_cnt                       - load FIFO occupancy
// Revision: 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int LD_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid,
   output logic                    alu_ready,
   input  logic [REG_ADDR_W-1:0]   alu_rd,
   input  logic [XLEN-1:0]         alu_data,
   input  logic                    ld_valid,
   output logic                    ld_ready,
   input  logic [REG_ADDR_W-1:0]   ld_rd,
   input  logic [XLEN-1:0]         ld_data,
   input  logic                    iss_valid,
   input  logic [REG_ADDR_W-1:0]   iss_rd,
   output logic                    we,
   output logic [REG_ADDR_W-1:0]   waddr,
   output logic [XLEN-1:0]         wdata,
   output logic [(1<<REG_ADDR_W)-1:0] busy,
   output logic [2:0]              ld_cnt
);

   localparam int c_CNT_W = $clog2(LD_DEPTH) + 1;

   logic                          w_fifo_full;
   logic                          w_fifo_empty;
   logic [c_CNT_W-1:0]            w_fifo_cnt;
   wb_rec_t                       w_ld_rec;
   wb_rec_t                       w_head;
   logic                          w_ld_push;
   logic                          w_alu_fire;
   wb_rec_t                       w_commit;
   logic                          w_commit_vld;
   logic                          w_we_next;
   logic [(1<<REG_ADDR_W)-1:0]    w_busy_next;

   logic                          r_we;
   logic [REG_ADDR_W-1:0]         r_waddr;
   logic [XLEN-1:0]               r_wdata;
   logic [(1<<REG_ADDR_W)-1:0]    r_busy;

   // Readiness depends only on state and reset, never on the valids.
   // The ALU waits until every pending load has drained, so the FIFO head
   // and an ALU result can never compete for the same commit slot.
   assign ld_ready   = !rst && !w_fifo_full;
   assign alu_ready  = !rst && w_fifo_empty;
   assign w_ld_push  = ld_valid && ld_ready;
   assign w_alu_fire = alu_valid && alu_ready;
   assign w_ld_rec.rd   = ld_rd;
   assign w_ld_rec.data = ld_data;

   wb_fifo #(
      .DEPTH (LD_DEPTH),
      .T     (wb_rec_t)
   ) u_ld_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_ld_push),
      .push_data (w_ld_rec),
      .pop       (!w_fifo_empty),
      .pop_data  (w_head),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty),
      .count     (w_fifo_cnt)
   );

   assign ld_cnt = 3'(w_fifo_cnt);

   // One commit per cycle: FIFO head first, otherwise an accepted ALU result.
   always_comb begin
      w_commit.rd   = alu_rd;
      w_commit.data = alu_data;
      w_commit_vld  = w_alu_fire;
      if (!w_fifo_empty) begin
         w_commit     = w_head;
         w_commit_vld = 1'b1;
      end
   end

   // Writes to x0 are consumed but never reach the register file.
   assign w_we_next = w_commit_vld && (w_commit.rd != '0);

   // Clear first, then set, so an issue racing a retire keeps the bit set.
   always_comb begin
      w_busy_next = r_busy;
      if (w_we_next) w_busy_next[w_commit.rd] = 1'b0;
      if (iss_valid && (iss_rd != '0)) w_busy_next[iss_rd] = 1'b1;
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_busy  <= '0;
      end else begin
         r_we   <= w_we_next;
         r_busy <= w_busy_next;
         if (w_we_next) begin
            r_waddr <= w_commit.rd;
            r_wdata <= w_commit.data;
         end
      end
   end

   assign we    = r_we;
   assign waddr = r_waddr;
   assign wdata = r_wdata;
   assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_ctrl
// Purpose : Self-checking bench for regfile_wb_ctrl (LD_DEPTH = 2).
//           A table of per-cycle stimulus with expected ready/port/scoreboard
//           values, a queue of expected register writes, and a hand-written
//           asynchronous-reset sequence.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] busy;
   logic [2:0]  ld_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_wb_ctrl #(.LD_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy),
      .ld_cnt    (ld_cnt)
   );

   typedef struct {
      logic        alu_v;
      logic [4:0]  alu_rd;
      logic [31:0] alu_d;
      logic        ld_v;
      logic [4:0]  ld_rd;
      logic [31:0] ld_d;
      logic        iss_v;
      logic [4:0]  iss_rd;
      logic        exp_alu_rdy;
      logic        exp_ld_rdy;
      logic        exp_we;
      logic [4:0]  exp_waddr;
      logic [31:0] exp_wdata;
      logic [2:0]  exp_cnt;
      logic [31:0] exp_busy;
   } vec_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] d;
   } exp_wr_t;

   vec_t    vecs [16];
   exp_wr_t sbq [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(
      input logic av, input logic [4:0] ard, input logic [31:0] ad,
      input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
      input logic iv, input logic [4:0] ird,
      input logic ear, input logic elr,
      input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
      input logic [2:0] ec, input logic [31:0] eb);
      vec_t v;
      v.alu_v = av;  v.alu_rd = ard; v.alu_d = ad;
      v.ld_v  = lv;  v.ld_rd  = lrd; v.ld_d  = ldd;
      v.iss_v = iv;  v.iss_rd = ird;
      v.exp_alu_rdy = ear; v.exp_ld_rdy = elr;
      v.exp_we = ewe; v.exp_waddr = ewa; v.exp_wdata = ewd;
      v.exp_cnt = ec; v.exp_busy = eb;
      return v;
   endfunction

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
      iss_valid = 1'b0; iss_rd = '0;
   endtask

   initial begin
      exp_wr_t e;

      //            alu v/rd/data        ld v/rd/data              iss v/rd   rdy a/l  we/waddr/wdata          cnt busy
      vecs[0]  = mk(0, 0, 0,             0, 0, 0,                  1, 5,      1, 1,    0, 0, 32'h0,            0, 32'h0000_0020);
      vecs[1]  = mk(1, 5, 32'h1234,      0, 0, 0,                  0, 0,      1, 1,    1, 5, 32'h1234,         0, 32'h0000_0000);
      vecs[2]  = mk(0, 0, 0,             1, 3, 32'hAAAA_0003,      1, 7,      1, 1,    0, 5, 32'h1234,         1, 32'h0000_0080);
      vecs[3]  = mk(1, 7, 32'h77,        0, 0, 0,                  0, 0,      0, 1,    1, 3, 32'hAAAA_0003,    0, 32'h0000_0080);
      vecs[4]  = mk(1, 7, 32'h77,        0, 0, 0,                  0, 0,      1, 1,    1, 7, 32'h77,           0, 32'h0000_0000);
      vecs[5]  = mk(0, 0, 0,             1, 0, 32'hFFFF_FFFF,      0, 0,      1, 1,    0, 7, 32'h77,           1, 32'h0000_0000);
      vecs[6]  = mk(0, 0, 0,             0, 0, 0,                  0, 0,      0, 1,    0, 7, 32'h77,           0, 32'h0000_0000);
      vecs[7]  = mk(0, 0, 0,             1, 9, 32'h99,             1, 9,      1, 1,    0, 7, 32'h77,           1, 32'h0000_0200);
      vecs[8]  = mk(0, 0, 0,             0, 0, 0,                  1, 9,      0, 1,    1, 9, 32'h99,           0, 32'h0000_0200);
      vecs[9]  = mk(0, 0, 0,             1, 1, 32'h11,             0, 0,      1, 1,    0, 9, 32'h99,           1, 32'h0000_0200);
      vecs[10] = mk(0, 0, 0,             1, 2, 32'h22,             0, 0,      0, 1,    1, 1, 32'h11,           1, 32'h0000_0200);
      vecs[11] = mk(0, 0, 0,             1, 4, 32'h44,             0, 0,      0, 1,    1, 2, 32'h22,           1, 32'h0000_0200);
      vecs[12] = mk(0, 0, 0,             0, 0, 0,                  0, 0,      0, 1,    1, 4, 32'h44,           0, 32'h0000_0200);
      vecs[13] = mk(1, 0, 32'h5,         0, 0, 0,                  1, 0,      1, 1,    0, 4, 32'h44,           0, 32'h0000_0200);
      vecs[14] = mk(1, 12, 32'hC,        1, 13, 32'hD,             1, 12,     1, 1,    1, 12, 32'hC,           1, 32'h0000_1200);
      vecs[15] = mk(0, 0, 0,             0, 0, 0,                  0, 0,      0, 1,    1, 13, 32'hD,           0, 32'h0000_1200);

      // Asynchronous reset before any clock edge.
      idle_inputs();
      rst = 1'b1;
      #1;
      check("reset_we", {31'b0, we}, 32'h0);
      check("reset_waddr", {27'b0, waddr}, 32'h0);
      check("reset_wdata", wdata, 32'h0);
      check("reset_busy", busy, 32'h0);
      check("reset_cnt", {29'b0, ld_cnt}, 32'h0);
      check("reset_ld_ready", {31'b0, ld_ready}, 32'h0);
      check("reset_alu_ready", {31'b0, alu_ready}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         alu_valid = vecs[i].alu_v; alu_rd = vecs[i].alu_rd; alu_data = vecs[i].alu_d;
         ld_valid  = vecs[i].ld_v;  ld_rd  = vecs[i].ld_rd;  ld_data  = vecs[i].ld_d;
         iss_valid = vecs[i].iss_v; iss_rd = vecs[i].iss_rd;
         #1;
         check($sformatf("v%0d_alu_ready", i), {31'b0, alu_ready}, {31'b0, vecs[i].exp_alu_rdy});
         check($sformatf("v%0d_ld_ready", i), {31'b0, ld_ready}, {31'b0, vecs[i].exp_ld_rdy});
         // Expected commit order: an ALU result accepted alongside a load
         // goes first, since the load still has to pass through the FIFO.
         if (vecs[i].alu_v && vecs[i].exp_alu_rdy && vecs[i].alu_rd != 5'd0)
            sbq.push_back({vecs[i].alu_rd, vecs[i].alu_d});
         if (vecs[i].ld_v && vecs[i].exp_ld_rdy && vecs[i].ld_rd != 5'd0)
            sbq.push_back({vecs[i].ld_rd, vecs[i].ld_d});
         @(posedge clk);
         #1;
         check($sformatf("v%0d_we", i), {31'b0, we}, {31'b0, vecs[i].exp_we});
         check($sformatf("v%0d_waddr", i), {27'b0, waddr}, {27'b0, vecs[i].exp_waddr});
         check($sformatf("v%0d_wdata", i), wdata, vecs[i].exp_wdata);
         check($sformatf("v%0d_ld_cnt", i), {29'b0, ld_cnt}, {29'b0, vecs[i].exp_cnt});
         check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
         if (we) begin
            if (sbq.size() == 0) begin
               check($sformatf("v%0d_sb_unexpected_write", i), 32'h1, 32'h0);
            end else begin
               e = sbq.pop_front();
               check($sformatf("v%0d_sb_waddr", i), {27'b0, waddr}, {27'b0, e.rd});
               check($sformatf("v%0d_sb_wdata", i), wdata, e.d);
            end
         end
      end
      check("sb_drained", sbq.size(), 32'h0);

      // Reset mid-stream: one load pending and a busy bit set, then an
      // asynchronous reset between edges.
      idle_inputs();
      ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h2020_2020;
      iss_valid = 1'b1; iss_rd = 5'd20;
      @(posedge clk);
      #1;
      idle_inputs();
      check("mid_cnt_before", {29'b0, ld_cnt}, 32'h1);
      check("mid_busy_before", busy, 32'h0010_1200);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_cnt", {29'b0, ld_cnt}, 32'h0);
      check("mid_rst_busy", busy, 32'h0);
      check("mid_rst_we", {31'b0, we}, 32'h0);
      check("mid_rst_waddr", {27'b0, waddr}, 32'h0);
      check("mid_rst_wdata", wdata, 32'h0);
      check("mid_rst_ld_ready", {31'b0, ld_ready}, 32'h0);
      check("mid_rst_alu_ready", {31'b0, alu_ready}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // First transfer on the first edge after release.
      alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
      #1;
      check("rel_alu_ready", {31'b0, alu_ready}, 32'h1);
      check("rel_ld_ready", {31'b0, ld_ready}, 32'h1);
      @(posedge clk);
      #1;
      idle_inputs();
      check("rel_we", {31'b0, we}, 32'h1);
      check("rel_waddr", {27'b0, waddr}, 32'h6);
      check("rel_wdata", wdata, 32'h66);

      // The discarded load must never be written.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("stale_we_%0d", k), {31'b0, we}, 32'h0);
         check($sformatf("stale_waddr_%0d", k), {27'b0, waddr}, 32'h6);
      end
      check("stale_cnt", {29'b0, ld_cnt}, 32'h0);
      check("stale_busy", busy, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
